// File: rtl/ir_pkg.sv
// ir_pkg: event and state encodings, NEC field offsets and the frame integrity check
package ir_pkg;
  typedef enum logic [1:0] {EVT_NONE = 2'b00, EVT_PRESS = 2'b01, EVT_HOLD = 2'b10, EVT_RELEASE = 2'b11} evt_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_SWAP} state_t;
  localparam int A_LSB = 24;
  localparam int AN_LSB = 16;
  localparam int C_LSB = 8;
  localparam int CN_LSB = 0;
  localparam int EVT_W = 18;
  function automatic logic frame_ok(input logic [31:0] code, input logic chk_addr);
    return (code[C_LSB+:8] == ~code[CN_LSB+:8]) && (!chk_addr || code[A_LSB+:8] == ~code[AN_LSB+:8]);
  endfunction
endpackage

// File: rtl/ir_key_controller_if.sv
// ir_key_controller_if: decoder frame inputs, host event FIFO handshake and status (master = decoder/host side, slave = controller)
interface ir_key_controller_if;
  import ir_pkg::*;
  logic code_valid;
  logic [31:0] code;
  logic repeat_press;
  logic evt_valid;
  logic evt_ready;
  evt_t evt_type;
  logic [7:0] evt_addr;
  logic [7:0] evt_cmd;
  logic held;
  logic [7:0] err_count;
  logic overflow;
  logic ovf_clr;
  modport master(output code_valid, code, repeat_press, evt_ready, ovf_clr,
                 input evt_valid, evt_type, evt_addr, evt_cmd, held, err_count, overflow);
  modport slave(input code_valid, code, repeat_press, evt_ready, ovf_clr,
                output evt_valid, evt_type, evt_addr, evt_cmd, held, err_count, overflow);
endinterface

// File: rtl/ir_evt_fifo.sv
// ir_evt_fifo: first-word-fall-through event FIFO (i_push/i_din in, i_pop/o_dout out, o_full/o_empty flags); push on full accepted only alongside a pop
module ir_evt_fifo import ir_pkg::*; #(
  parameter int W = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_wr, w_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);
  assign o_dout = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/ir_key_controller.sv
// ir_key_controller: turns decoder frames (bus.code_valid/code/repeat_press) into PRESS/HOLD/RELEASE events on the bus FIFO, with held, err_count and sticky overflow status
module ir_key_controller import ir_pkg::*; #(
  parameter int CODEBITS = 32,
  parameter int RELEASE_TIMEOUT = 12_000_000,
  parameter int HOLD_DIV = 1,
  parameter int CHECK_ADDR = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ir_key_controller_if.slave bus
);
  localparam int TW = RELEASE_TIMEOUT > 1 ? $clog2(RELEASE_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(RELEASE_TIMEOUT - 1);
  localparam logic [7:0] REP_LAST = 8'(HOLD_DIV - 1);
  state_t r_state, w_state_nxt;
  logic [CODEBITS-1:0] w_code;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0] r_rep, w_rep_nxt, r_addr, r_cmd, w_addr, w_cmd, r_err;
  logic r_ovf, w_ok, w_full_ok, w_bad, w_rep_f, w_same, w_latch, w_push, w_pop, w_full, w_empty;
  logic [EVT_W-1:0] w_evt, w_head;
  assign w_code = bus.code;
  assign w_addr = w_code[A_LSB+:8];
  assign w_cmd = w_code[C_LSB+:8];
  assign w_ok = frame_ok(w_code, CHECK_ADDR != 0);
  assign w_full_ok = bus.code_valid && !bus.repeat_press && w_ok && r_state != ST_SWAP;
  assign w_bad = bus.code_valid && !bus.repeat_press && !w_ok && r_state != ST_SWAP;
  assign w_rep_f = bus.code_valid && bus.repeat_press;
  assign w_same = w_addr == r_addr && w_cmd == r_cmd;
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rep_nxt = r_rep;
    w_latch = 1'b0;
    w_push = 1'b0;
    w_evt = {EVT_PRESS, w_addr, w_cmd};
    case (r_state)
      ST_IDLE:
        if (w_full_ok) begin
          w_push = 1'b1;
          w_latch = 1'b1;
          w_timer_nxt = T_LOAD;
          w_rep_nxt = '0;
          w_state_nxt = ST_HELD;
        end
      ST_HELD:
        if (w_full_ok) begin
          w_timer_nxt = T_LOAD;
          w_rep_nxt = '0;
          if (!w_same) begin
            w_push = 1'b1;
            w_evt = {EVT_RELEASE, r_addr, r_cmd};
            w_latch = 1'b1;
            w_state_nxt = ST_SWAP;
          end
        end else if (w_rep_f) begin
          w_timer_nxt = T_LOAD;
          w_push = r_rep == REP_LAST;
          w_evt = {EVT_HOLD, r_addr, r_cmd};
          w_rep_nxt = w_push ? '0 : r_rep + 1'b1;
        end else if (!bus.code_valid) begin
          if (r_timer == '0) begin
            w_push = 1'b1;
            w_evt = {EVT_RELEASE, r_addr, r_cmd};
            w_state_nxt = ST_IDLE;
          end else w_timer_nxt = r_timer - 1'b1;
        end
      ST_SWAP: begin
        w_push = 1'b1;
        w_evt = {EVT_PRESS, r_addr, r_cmd};
        w_timer_nxt = r_timer - 1'b1;
        w_state_nxt = ST_HELD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_timer <= '0;
      r_rep <= '0;
      r_addr <= '0;
      r_cmd <= '0;
      r_err <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      r_rep <= w_rep_nxt;
      if (w_latch) begin
        r_addr <= w_addr;
        r_cmd <= w_cmd;
      end
      r_err <= bus.ovf_clr ? '0 : (w_bad && r_err != 8'hFF) ? r_err + 1'b1 : r_err;
      r_ovf <= bus.ovf_clr ? 1'b0 : (w_push && w_full && !w_pop) ? 1'b1 : r_ovf;
    end
  assign w_pop = bus.evt_ready && !w_empty;
  ir_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_din(w_evt), .i_pop(w_pop),
    .o_dout(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  assign bus.evt_valid = !w_empty;
  assign bus.evt_type = evt_t'(w_head[17:16]);
  assign bus.evt_addr = w_head[15:8];
  assign bus.evt_cmd = w_head[7:0];
  assign bus.held = r_state != ST_IDLE;
  assign bus.err_count = r_err;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_ir_key_controller.sv
// tb_ir_key_controller: directed frames with a scoreboard queue checked by a forked event monitor
module tb_ir_key_controller;
  import ir_pkg::*;
  typedef struct {logic [17:0] ev; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int t, t1;
  exp_t q[$];
  exp_t e;
  ir_key_controller_if ifc();
  ir_key_controller #(.CODEBITS(32), .RELEASE_TIMEOUT(100), .HOLD_DIV(2), .CHECK_ADDR(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [31:0] c, input logic rp, output int at);
    ifc.code = c;
    ifc.repeat_press = rp;
    ifc.code_valid = 1'b1;
    at = cyc;
    step(1);
    ifc.code_valid = 1'b0;
  endtask
  task automatic clr();
    ifc.ovf_clr = 1'b1;
    step(1);
    ifc.ovf_clr = 1'b0;
  endtask
  function automatic void ex(input logic [1:0] ty, input logic [7:0] a, input logic [7:0] c, input int at);
    q.push_back('{ev: {ty, a, c}, cyc: at});
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    ifc.code_valid = 1'b0;
    ifc.code = '0;
    ifc.repeat_press = 1'b0;
    ifc.evt_ready = 1'b1;
    ifc.ovf_clr = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst && ifc.evt_valid && ifc.evt_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_evt got=%h exp=none cycle=%0d", {ifc.evt_type, ifc.evt_addr, ifc.evt_cmd}, cyc);
          end else begin
            e = q.pop_front();
            chk("evt_data", {14'd0, ifc.evt_type, ifc.evt_addr, ifc.evt_cmd}, {14'd0, e.ev});
            if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
          end
        end
      end
    join_none
    step(3);
    chk("rst_evt_valid", ifc.evt_valid, 0);
    chk("rst_evt_word", {ifc.evt_type, ifc.evt_addr, ifc.evt_cmd}, 0);
    chk("rst_held", ifc.held, 0);
    chk("rst_err", ifc.err_count, 0);
    chk("rst_ovf", ifc.overflow, 0);
    rst = 1'b0;
    step(2);
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, t + 1);
    ex(EVT_RELEASE, 8'h00, 8'h45, t + 101);
    chk("a_held", ifc.held, 1);
    step(105);
    chk("a_released", ifc.held, 0);
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, t + 1);
    for (int i = 1; i <= 4; i++) begin
      step(49);
      drive(32'h0, 1'b1, t1);
      if (i % 2 == 0) ex(EVT_HOLD, 8'h00, 8'h45, t1 + 1);
    end
    ex(EVT_RELEASE, 8'h00, 8'h45, t1 + 101);
    chk("b_held", ifc.held, 1);
    step(105);
    chk("b_released", ifc.held, 0);
    drive(32'h00FF_45BB, 1'b0, t);
    chk("c_err1", ifc.err_count, 1);
    chk("c_held", ifc.held, 0);
    drive(32'h00FE_45BA, 1'b0, t);
    chk("c_err2", ifc.err_count, 2);
    drive(32'h0, 1'b1, t);
    chk("c_idle_rep_err", ifc.err_count, 2);
    chk("c_idle_rep_held", ifc.held, 0);
    clr();
    chk("c_err_clr", ifc.err_count, 0);
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, t + 1);
    step(10);
    drive(32'h00FF_46B9, 1'b0, t1);
    ex(EVT_RELEASE, 8'h00, 8'h45, t1 + 1);
    ex(EVT_PRESS, 8'h00, 8'h46, t1 + 2);
    ex(EVT_RELEASE, 8'h00, 8'h46, t1 + 101);
    chk("d_held_swap", ifc.held, 1);
    step(1);
    chk("d_held_after", ifc.held, 1);
    step(110);
    chk("d_released", ifc.held, 0);
    ifc.evt_ready = 1'b0;
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, -1);
    for (int i = 0; i < 10; i++) drive(32'h0, 1'b1, t1);
    for (int i = 0; i < 3; i++) ex(EVT_HOLD, 8'h00, 8'h45, -1);
    ex(EVT_RELEASE, 8'h00, 8'h45, -1);
    chk("e_ovf_set", ifc.overflow, 1);
    chk("e_valid", ifc.evt_valid, 1);
    chk("e_head_press", ifc.evt_type, EVT_PRESS);
    ifc.evt_ready = 1'b1;
    step(110);
    chk("e_released", ifc.held, 0);
    chk("e_ovf_sticky", ifc.overflow, 1);
    clr();
    chk("e_ovf_clr", ifc.overflow, 0);
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, t + 1);
    step(99);
    drive(32'h0, 1'b1, t1);
    ex(EVT_RELEASE, 8'h00, 8'h45, t + 201);
    chk("f_held_at_zero", ifc.held, 1);
    step(105);
    chk("f_released", ifc.held, 0);
    drive(32'h00FF_45BA, 1'b0, t);
    ex(EVT_PRESS, 8'h00, 8'h45, t + 1);
    step(5);
    rst = 1'b1;
    step(1);
    chk("g_held", ifc.held, 0);
    chk("g_valid", ifc.evt_valid, 0);
    chk("g_word", {ifc.evt_type, ifc.evt_addr, ifc.evt_cmd}, 0);
    rst = 1'b0;
    step(120);
    chk("g_held_after", ifc.held, 0);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
